// File: rtl/axi_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_responder_pkg
// Shared definitions for the AXI memory responder: AXI burst and response
// encodings, the write/read FSM state types and a small burst helper.
// No ports; imported by the responder top.
// ---------------------------------------------------------------------------
package axi_mem_responder_pkg;

    // AXI burst type encodings (AxBURST)
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // AXI response encodings (xRESP)
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel FSM states
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wrState_e;

    // Read channel FSM states
    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rdState_e;

    // Only INCR bursts step the word index; FIXED, WRAP and the reserved
    // encoding all keep hitting the same word.
    function automatic logic burstAdvances(input logic [1:0] burst);
        return burst == BURST_INCR;
    endfunction

endpackage

// File: rtl/axi_mem_bram.sv
// ---------------------------------------------------------------------------
// axi_mem_bram
// Simple dual-port RAM: one byte-enabled write port, one registered read port
// with 1-cycle latency. A read and write to the same word in the same cycle
// returns the old contents (read-first). Contents are never reset.
// Ports:
//   clk_i     clock
//   wrEn_i    per-byte write enables
//   wrAddr_i  write word index
//   wrData_i  write data
//   rdEn_i    read strobe; rdData_o updates on the following edge
//   rdAddr_i  read word index
//   rdData_o  registered read data, held while rdEn_i is low
// ---------------------------------------------------------------------------
module axi_mem_bram #(
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int ADDR_BITS  = 12
) (
    input  logic                  clk_i,
    input  logic [MASK_WIDTH-1:0] wrEn_i,
    input  logic [ADDR_BITS-1:0]  wrAddr_i,
    input  logic [DATA_WIDTH-1:0] wrData_i,
    input  logic                  rdEn_i,
    input  logic [ADDR_BITS-1:0]  rdAddr_i,
    output logic [DATA_WIDTH-1:0] rdData_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
    logic [DATA_WIDTH-1:0] rdData_q;

    // Byte-lane writes: only lanes with their enable set are touched, the
    // rest of the word keeps its previous contents.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (wrEn_i[i]) begin
                mem[wrAddr_i][i*8 +: 8] <= wrData_i[i*8 +: 8];
            end
        end
    end

    // Registered read. Because the array update above is non-blocking, this
    // samples the pre-write word on a same-cycle collision (read-first).
    always_ff @(posedge clk_i) begin
        if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/axi_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_mem_responder
// AXI4 slave backed by an on-chip RAM, standing in for a DDR controller.
// After reset a calibration counter holds the interface off for CALIB_CYCLES
// cycles. Independent write (AW/W/B) and read (AR/R) FSMs then serve full-word
// bursts; size/lock/cache/prot/qos are accepted and ignored.
// Ports:
//   ui_clk, ui_rst           clock, synchronous active-high reset
//   init_calib_complete      high once calibration has elapsed
//   s_axi_aw*/s_axi_awready  write address channel
//   s_axi_w*/s_axi_wready    write data channel
//   s_axi_b*/s_axi_bready    write response channel
//   s_axi_ar*/s_axi_arready  read address channel
//   s_axi_r*/s_axi_rready    read data channel
// ---------------------------------------------------------------------------
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int CALIB_CYCLES   = 64
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    output logic                      init_calib_complete,
    // AW
    input  logic [3:0]                s_axi_awid,
    input  logic [APP_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic [0:0]                s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic [3:0]                s_axi_awqos,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    // W
    input  logic [APP_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [APP_MASK_WIDTH-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    // B
    output logic [3:0]                s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    // AR
    input  logic [3:0]                s_axi_arid,
    input  logic [APP_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic [0:0]                s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic [3:0]                s_axi_arqos,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    // R
    output logic [3:0]                s_axi_rid,
    output logic [APP_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int IDX_W   = MEM_WORDS_LOG2;
    localparam int CALIB_W = $clog2(CALIB_CYCLES + 1);

    // ------------------------------------------------------------------
    // Calibration
    // ------------------------------------------------------------------
    logic [CALIB_W-1:0] calibCnt_q;
    logic               calibDone_q;

    // Counts cycles since reset release; the done flag latches and the
    // counter freezes once CALIB_CYCLES edges have gone by.
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            calibCnt_q  <= '0;
            calibDone_q <= 1'b0;
        end else if (!calibDone_q) begin
            if (calibCnt_q == CALIB_W'(CALIB_CYCLES - 1)) begin
                calibDone_q <= 1'b1;
            end
            calibCnt_q <= calibCnt_q + CALIB_W'(1);
        end
    end

    assign init_calib_complete = calibDone_q;

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    wrState_e          wState_q, wState_d;
    logic [3:0]        wId_q, wId_d;
    logic [IDX_W-1:0]  wIdx_q, wIdx_d;
    logic [7:0]        wLen_q, wLen_d;
    logic [1:0]        wBurst_q, wBurst_d;
    logic [8:0]        wBeat_q, wBeat_d;
    logic              wErr_q, wErr_d;
    logic [1:0]        bResp_q, bResp_d;

    logic awHs, wHs, bHs;

    assign s_axi_awready = calibDone_q && (wState_q == W_IDLE);
    assign s_axi_wready  = calibDone_q && (wState_q == W_DATA);
    assign s_axi_bvalid  = (wState_q == W_RESP);
    assign s_axi_bid     = wId_q;
    assign s_axi_bresp   = bResp_q;

    assign awHs = s_axi_awvalid && s_axi_awready;
    assign wHs  = s_axi_wvalid && s_axi_wready;
    assign bHs  = s_axi_bvalid && s_axi_bready;

    // Write state register; the burst context is dropped on reset so a
    // half-finished burst never produces a response.
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            wState_q <= W_IDLE;
            wId_q    <= '0;
            wIdx_q   <= '0;
            wLen_q   <= '0;
            wBurst_q <= '0;
            wBeat_q  <= '0;
            wErr_q   <= 1'b0;
            bResp_q  <= RESP_OKAY;
        end else begin
            wState_q <= wState_d;
            wId_q    <= wId_d;
            wIdx_q   <= wIdx_d;
            wLen_q   <= wLen_d;
            wBurst_q <= wBurst_d;
            wBeat_q  <= wBeat_d;
            wErr_q   <= wErr_d;
            bResp_q  <= bResp_d;
        end
    end

    // Write next-state. The burst length alone decides the final beat; a
    // wlast seen early is remembered in wErr and turns the response into
    // SLVERR, as does a missing wlast on the final beat.
    always_comb begin
        wState_d = wState_q;
        wId_d    = wId_q;
        wIdx_d   = wIdx_q;
        wLen_d   = wLen_q;
        wBurst_d = wBurst_q;
        wBeat_d  = wBeat_q;
        wErr_d   = wErr_q;
        bResp_d  = bResp_q;
        case (wState_q)
            W_IDLE: begin
                if (awHs) begin
                    wId_d    = s_axi_awid;
                    wIdx_d   = s_axi_awaddr[IDX_W+3:4];
                    wLen_d   = s_axi_awlen;
                    wBurst_d = s_axi_awburst;
                    wBeat_d  = '0;
                    wErr_d   = 1'b0;
                    wState_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wHs) begin
                    wBeat_d = wBeat_q + 9'd1;
                    if (burstAdvances(wBurst_q)) begin
                        wIdx_d = wIdx_q + IDX_W'(1);
                    end
                    if (wBeat_q == {1'b0, wLen_q}) begin
                        bResp_d  = (s_axi_wlast && !wErr_q) ? RESP_OKAY : RESP_SLVERR;
                        wState_d = W_RESP;
                    end else if (s_axi_wlast) begin
                        wErr_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (bHs) begin
                    wState_d = W_IDLE;
                end
            end
            default: wState_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    rdState_e          rState_q, rState_d;
    logic [3:0]        rId_q, rId_d;
    logic [IDX_W-1:0]  rIdx_q, rIdx_d;
    logic [7:0]        rLen_q, rLen_d;
    logic [1:0]        rBurst_q, rBurst_d;
    logic [8:0]        rBeat_q, rBeat_d;

    logic arHs, rHs;

    assign s_axi_arready = calibDone_q && (rState_q == R_IDLE);
    assign s_axi_rvalid  = (rState_q == R_DATA);
    assign s_axi_rid     = rId_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_rlast   = (rState_q == R_DATA) && (rBeat_q == {1'b0, rLen_q});

    assign arHs = s_axi_arvalid && s_axi_arready;
    assign rHs  = s_axi_rvalid && s_axi_rready;

    // Read state register; reset abandons any burst in flight.
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            rState_q <= R_IDLE;
            rId_q    <= '0;
            rIdx_q   <= '0;
            rLen_q   <= '0;
            rBurst_q <= '0;
            rBeat_q  <= '0;
        end else begin
            rState_q <= rState_d;
            rId_q    <= rId_d;
            rIdx_q   <= rIdx_d;
            rLen_q   <= rLen_d;
            rBurst_q <= rBurst_d;
            rBeat_q  <= rBeat_d;
        end
    end

    // Read next-state. Each beat costs a FETCH cycle (RAM read issued) and a
    // DATA cycle (registered RAM output presented). The RAM only reads in
    // FETCH, so rdata stays frozen for as long as the master stalls in DATA.
    always_comb begin
        rState_d = rState_q;
        rId_d    = rId_q;
        rIdx_d   = rIdx_q;
        rLen_d   = rLen_q;
        rBurst_d = rBurst_q;
        rBeat_d  = rBeat_q;
        case (rState_q)
            R_IDLE: begin
                if (arHs) begin
                    rId_d    = s_axi_arid;
                    rIdx_d   = s_axi_araddr[IDX_W+3:4];
                    rLen_d   = s_axi_arlen;
                    rBurst_d = s_axi_arburst;
                    rBeat_d  = '0;
                    rState_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rState_d = R_DATA;
            end
            R_DATA: begin
                if (rHs) begin
                    if (s_axi_rlast) begin
                        rState_d = R_IDLE;
                    end else begin
                        rBeat_d = rBeat_q + 9'd1;
                        if (burstAdvances(rBurst_q)) begin
                            rIdx_d = rIdx_q + IDX_W'(1);
                        end
                        rState_d = R_FETCH;
                    end
                end
            end
            default: rState_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Backing memory
    // ------------------------------------------------------------------
    logic [APP_MASK_WIDTH-1:0] memWrEn;

    assign memWrEn = wHs ? s_axi_wstrb : '0;

    axi_mem_bram #(
        .DATA_WIDTH (APP_DATA_WIDTH),
        .MASK_WIDTH (APP_MASK_WIDTH),
        .ADDR_BITS  (IDX_W)
    ) u_bram (
        .clk_i    (ui_clk),
        .wrEn_i   (memWrEn),
        .wrAddr_i (wIdx_q),
        .wrData_i (s_axi_wdata),
        .rdEn_i   (rState_q == R_FETCH),
        .rdAddr_i (rIdx_q),
        .rdData_o (s_axi_rdata)
    );

    // Sideband fields and out-of-range address bits have no effect on this
    // memory; fold them together so they are visibly consumed.
    logic unusedInputs;
    assign unusedInputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                            s_axi_awqos, s_axi_awaddr, s_axi_arsize, s_axi_arlock,
                            s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_araddr};

endmodule

// File: tb/tb_axi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_responder
// Directed bench for axi_mem_responder: single-beat vector table followed by
// hand-written burst, error, concurrency and reset sequences.
// ---------------------------------------------------------------------------
module tb_axi_mem_responder;
    import axi_mem_responder_pkg::*;

    logic         ui_clk = 1'b0;
    logic         ui_rst;
    logic         init_calib_complete;
    logic [3:0]   s_axi_awid;
    logic [27:0]  s_axi_awaddr;
    logic [7:0]   s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [1:0]   s_axi_awburst;
    logic [0:0]   s_axi_awlock;
    logic [3:0]   s_axi_awcache;
    logic [2:0]   s_axi_awprot;
    logic [3:0]   s_axi_awqos;
    logic         s_axi_awvalid;
    logic         s_axi_awready;
    logic [127:0] s_axi_wdata;
    logic [15:0]  s_axi_wstrb;
    logic         s_axi_wlast;
    logic         s_axi_wvalid;
    logic         s_axi_wready;
    logic [3:0]   s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready;
    logic [3:0]   s_axi_arid;
    logic [27:0]  s_axi_araddr;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [1:0]   s_axi_arburst;
    logic [0:0]   s_axi_arlock;
    logic [3:0]   s_axi_arcache;
    logic [2:0]   s_axi_arprot;
    logic [3:0]   s_axi_arqos;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [3:0]   s_axi_rid;
    logic [127:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;

    axi_mem_responder dut (
        .ui_clk              (ui_clk),
        .ui_rst              (ui_rst),
        .init_calib_complete (init_calib_complete),
        .s_axi_awid          (s_axi_awid),
        .s_axi_awaddr        (s_axi_awaddr),
        .s_axi_awlen         (s_axi_awlen),
        .s_axi_awsize        (s_axi_awsize),
        .s_axi_awburst       (s_axi_awburst),
        .s_axi_awlock        (s_axi_awlock),
        .s_axi_awcache       (s_axi_awcache),
        .s_axi_awprot        (s_axi_awprot),
        .s_axi_awqos         (s_axi_awqos),
        .s_axi_awvalid       (s_axi_awvalid),
        .s_axi_awready       (s_axi_awready),
        .s_axi_wdata         (s_axi_wdata),
        .s_axi_wstrb         (s_axi_wstrb),
        .s_axi_wlast         (s_axi_wlast),
        .s_axi_wvalid        (s_axi_wvalid),
        .s_axi_wready        (s_axi_wready),
        .s_axi_bid           (s_axi_bid),
        .s_axi_bresp         (s_axi_bresp),
        .s_axi_bvalid        (s_axi_bvalid),
        .s_axi_bready        (s_axi_bready),
        .s_axi_arid          (s_axi_arid),
        .s_axi_araddr        (s_axi_araddr),
        .s_axi_arlen         (s_axi_arlen),
        .s_axi_arsize        (s_axi_arsize),
        .s_axi_arburst       (s_axi_arburst),
        .s_axi_arlock        (s_axi_arlock),
        .s_axi_arcache       (s_axi_arcache),
        .s_axi_arprot        (s_axi_arprot),
        .s_axi_arqos         (s_axi_arqos),
        .s_axi_arvalid       (s_axi_arvalid),
        .s_axi_arready       (s_axi_arready),
        .s_axi_rid           (s_axi_rid),
        .s_axi_rdata         (s_axi_rdata),
        .s_axi_rresp         (s_axi_rresp),
        .s_axi_rlast         (s_axi_rlast),
        .s_axi_rvalid        (s_axi_rvalid),
        .s_axi_rready        (s_axi_rready)
    );

    always #5 ui_clk = ~ui_clk;

    int checks = 0;
    int fails  = 0;

    logic [127:0] wrData  [256];
    logic [127:0] expData [256];

    typedef struct {
        logic [3:0]   id;
        logic [27:0]  addr;
        logic [15:0]  strb;
        logic [127:0] wdata;
        logic [127:0] expRead;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [127:0] patA(input int k);
        return {4{32'hA000_0000 + 32'(k)}};
    endfunction

    function automatic logic [127:0] patC(input int k);
        return {4{32'hC0DE_0000 + 32'(k)}};
    endfunction

    function automatic logic [127:0] patL(input int k);
        return {32'h1234_5678, 32'(k * 3 + 1), 32'hFFFF_0000 ^ 32'(k), 32'(k)};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic waitCalib();
        int n = 0;
        while (!init_calib_complete && n < 200) begin
            checkOutput("readyBeforeCalib", {s_axi_awready, s_axi_arready, s_axi_wready}, 0);
            n++;
            @(negedge ui_clk);
        end
        checkOutput("calibCycles", n, 64);
        checkOutput("calibHigh", init_calib_complete, 1);
    endtask

    task automatic applyStimulus_aw(input logic [3:0] id, input logic [27:0] addr,
                                    input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
        s_axi_awsize = 3'd4; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 500) begin @(negedge ui_clk); n++; end
        if (n >= 500) timeoutFail("awHandshake");
        @(negedge ui_clk);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic applyStimulus_w(input logic [127:0] data, input logic [15:0] strb, input logic last);
        int n = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 500) begin @(negedge ui_clk); n++; end
        if (n >= 500) timeoutFail("wHandshake");
        @(negedge ui_clk);
        s_axi_wvalid = 1'b0;
    endtask

    task automatic applyStimulus_ar(input logic [3:0] id, input logic [27:0] addr,
                                    input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
        s_axi_arsize = 3'd4; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 500) begin @(negedge ui_clk); n++; end
        if (n >= 500) timeoutFail("arHandshake");
        @(negedge ui_clk);
        s_axi_arvalid = 1'b0;
    endtask

    // Waits for bvalid, optionally stalls bready, then checks the response.
    task automatic checkB(input logic [3:0] id, input logic [1:0] resp, input int stall);
        int n = 0;
        s_axi_bready = 1'b0;
        while (!s_axi_bvalid && n < 500) begin @(negedge ui_clk); n++; end
        if (n >= 500) timeoutFail("bValid");
        for (int i = 0; i < stall; i++) begin
            checkOutput("bvalidHeld", s_axi_bvalid, 1);
            @(negedge ui_clk);
        end
        s_axi_bready = 1'b1;
        checkOutput("bvalid", s_axi_bvalid, 1);
        checkOutput("bid", s_axi_bid, id);
        checkOutput("bresp", s_axi_bresp, resp);
        @(negedge ui_clk);
        s_axi_bready = 1'b0;
        checkOutput("bvalidDropped", s_axi_bvalid, 0);
    endtask

    task automatic writeBurst(input logic [3:0] id, input logic [27:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input int stall);
        applyStimulus_aw(id, addr, len, burst);
        for (int k = 0; k <= int'(len); k++) begin
            applyStimulus_w(wrData[k], 16'hFFFF, k == int'(len));
        end
        checkB(id, RESP_OKAY, stall);
    endtask

    // Collects len+1 beats against expData. mode 0: rready always high,
    // mode 1: toggles every cycle, mode 2: high one cycle in three.
    task automatic checkOutput_read(input logic [3:0] id, input logic [7:0] len, input int mode);
        int beat = 0;
        int n = 0;
        logic held = 1'b0;
        logic [127:0] prevData = '0;
        logic [4:0] prevCtl = '0;
        s_axi_rready = 1'b0;
        while (beat <= int'(len) && n < 3000) begin
            case (mode)
                1:       s_axi_rready = ~s_axi_rready;
                2:       s_axi_rready = (n % 3 == 2);
                default: s_axi_rready = 1'b1;
            endcase
            if (s_axi_rvalid) begin
                if (held) begin
                    checkOutput("rdataStable", s_axi_rdata, prevData);
                    checkOutput("rctlStable", {s_axi_rid, s_axi_rlast}, prevCtl);
                end
                if (s_axi_rready) begin
                    checkOutput("rdata", s_axi_rdata, expData[beat]);
                    checkOutput("rlast", s_axi_rlast, beat == int'(len));
                    checkOutput("rid", s_axi_rid, id);
                    checkOutput("rresp", s_axi_rresp, RESP_OKAY);
                    beat++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prevData = s_axi_rdata;
                    prevCtl = {s_axi_rid, s_axi_rlast};
                end
            end
            @(negedge ui_clk);
            n++;
        end
        s_axi_rready = 1'b0;
        if (beat <= int'(len)) timeoutFail("readBurst");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int n;

        ui_rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awlock = '0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arlock = '0; s_axi_arcache = '0; s_axi_arprot = '0;
        s_axi_arqos = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;

        vecs[0] = '{4'h1, 28'h000_0100, 16'hFFFF,
                    {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444},
                    {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444}};
        vecs[1] = '{4'h2, 28'h000_0100, 16'h000F,
                    {96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 32'hDEAD_BEEF},
                    {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF}};
        vecs[2] = '{4'h3, 28'h001_0100, 16'hF000,
                    {32'hCAFE_F00D, 96'h0},
                    {32'hCAFE_F00D, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF}};
        vecs[3] = '{4'h4, 28'h000_010F, 16'h00F0,
                    {64'h0, 32'h1234_5678, 32'h0},
                    {32'hCAFE_F00D, 32'h2222_2222, 32'h1234_5678, 32'hDEAD_BEEF}};
        vecs[4] = '{4'h5, 28'h000_0100, 16'h0000,
                    {128{1'b1}},
                    {32'hCAFE_F00D, 32'h2222_2222, 32'h1234_5678, 32'hDEAD_BEEF}};
        vecs[5] = '{4'hE, 28'h000_FFF0, 16'hFFFF,
                    128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100,
                    128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100};

        // Reset values and calibration window
        repeat (3) @(negedge ui_clk);
        checkOutput("rstCalib", init_calib_complete, 0);
        checkOutput("rstReady", {s_axi_awready, s_axi_arready, s_axi_wready}, 0);
        checkOutput("rstValid", {s_axi_bvalid, s_axi_rvalid, s_axi_rlast}, 0);
        checkOutput("rstIdsResp", {s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp}, 0);
        ui_rst = 1'b0;
        waitCalib();

        // Vector table: single-beat write then single-beat read of the same word
        for (int v = 0; v < 6; v++) begin
            applyStimulus_aw(vecs[v].id, vecs[v].addr, 8'd0, BURST_INCR);
            applyStimulus_w(vecs[v].wdata, vecs[v].strb, 1'b1);
            checkB(vecs[v].id, RESP_OKAY, 0);
            expData[0] = vecs[v].expRead;
            applyStimulus_ar(vecs[v].id ^ 4'hF, vecs[v].addr, 8'd0, BURST_INCR);
            checkOutput_read(vecs[v].id ^ 4'hF, 8'd0, 0);
        end

        // INCR 4-beat write/read with rready toggling
        $display("[TB] INCR burst with toggled rready");
        for (int k = 0; k < 4; k++) begin
            wrData[k] = 128'(k + 1);
            expData[k] = 128'(k + 1);
        end
        writeBurst(4'h6, 28'h0, 8'd3, BURST_INCR, 0);
        applyStimulus_ar(4'h7, 28'h0, 8'd3, BURST_INCR);
        checkOutput_read(4'h7, 8'd3, 1);

        // Early wlast: still two beats, SLVERR
        $display("[TB] early wlast");
        applyStimulus_aw(4'h8, 28'h3000, 8'd1, BURST_INCR);
        applyStimulus_w(128'h5151, 16'hFFFF, 1'b1);
        checkOutput("earlyLastNoB", s_axi_bvalid, 0);
        checkOutput("earlyLastWready", s_axi_wready, 1);
        applyStimulus_w(128'h5252, 16'hFFFF, 1'b1);
        checkB(4'h8, RESP_SLVERR, 0);
        expData[0] = 128'h5151;
        expData[1] = 128'h5252;
        applyStimulus_ar(4'h8, 28'h3000, 8'd1, BURST_INCR);
        checkOutput_read(4'h8, 8'd1, 0);

        // FIXED burst: every beat hits the same word
        for (int k = 0; k < 3; k++) wrData[k] = 128'(k + 7);
        writeBurst(4'hA, 28'h4000, 8'd2, BURST_FIXED, 0);
        expData[0] = 128'd9;
        applyStimulus_ar(4'hA, 28'h4000, 8'd0, BURST_INCR);
        checkOutput_read(4'hA, 8'd0, 0);

        // Concurrent write and read to disjoint regions with a B stall
        $display("[TB] concurrent bursts");
        for (int k = 0; k < 8; k++) wrData[k] = patC(k);
        writeBurst(4'h1, 28'h1000, 8'd7, BURST_INCR, 0);
        for (int k = 0; k < 8; k++) begin
            wrData[k] = patA(k);
            expData[k] = patC(k);
        end
        fork
            writeBurst(4'h2, 28'h2000, 8'd7, BURST_INCR, 10);
            begin
                applyStimulus_ar(4'h3, 28'h1000, 8'd7, BURST_INCR);
                checkOutput_read(4'h3, 8'd7, 2);
            end
        join
        for (int k = 0; k < 8; k++) expData[k] = patA(k);
        applyStimulus_ar(4'h4, 28'h2000, 8'd7, BURST_INCR);
        checkOutput_read(4'h4, 8'd7, 0);

        // 256-beat burst wrapping past the top of memory
        $display("[TB] 256-beat wrapping burst");
        for (int k = 0; k < 256; k++) begin
            wrData[k] = patL(k);
            expData[k] = patL(k);
        end
        writeBurst(4'hB, 28'hFF80, 8'd255, BURST_INCR, 0);
        applyStimulus_ar(4'hC, 28'hFF80, 8'd255, BURST_INCR);
        checkOutput_read(4'hC, 8'd255, 0);
        expData[0] = patL(8);
        applyStimulus_ar(4'hD, 28'h0, 8'd0, BURST_INCR);
        checkOutput_read(4'hD, 8'd0, 0);

        // Reset during beat 3 of an 8-beat read
        $display("[TB] reset mid read");
        applyStimulus_ar(4'h9, 28'h2000, 8'd7, BURST_INCR);
        s_axi_rready = 1'b1;
        acc = 0;
        n = 0;
        while (n < 200) begin
            if (s_axi_rvalid) begin
                if (acc == 2) break;
                checkOutput("preRstBeat", s_axi_rdata, patA(acc));
                acc++;
            end
            @(negedge ui_clk);
            n++;
        end
        if (n >= 200) timeoutFail("preRstBeats");
        s_axi_rready = 1'b0;
        ui_rst = 1'b1;
        @(negedge ui_clk);
        checkOutput("rstRvalid", s_axi_rvalid, 0);
        checkOutput("rstRidLast", {s_axi_rid, s_axi_rlast}, 0);
        checkOutput("rstCalibLow", init_calib_complete, 0);
        checkOutput("rstArready", s_axi_arready, 0);
        ui_rst = 1'b0;
        waitCalib();
        expData[0] = patA(2);
        applyStimulus_ar(4'h5, 28'h2020, 8'd0, BURST_INCR);
        checkOutput_read(4'h5, 8'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
